// File: rtl/elevator_motion_controller.sv
// Four-floor elevator car controller: accepts one one-hot floor request,
// drives the car floor by floor, holds the door open, then reports served.
module elevator_motion_controller #(
   parameter int TRAVEL_TICKS = 100,
   parameter int DOOR_TICKS   = 200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] ctrl_load,
   output logic [3:0] ctrl_seq,
   output logic [3:0] floor,
   output logic       motor_up,
   output logic       motor_down,
   output logic       door_open,
   output logic       served
);

   localparam int CW = 25;
   localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_TICKS - 1);
   localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE,
      MOVE_UP,
      MOVE_DOWN,
      DOOR
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      ctrl_seq_q, ctrl_seq_d;
   logic [3:0]      floor_q, floor_d;
   logic [CW-1:0]   travel_cnt_q, travel_cnt_d;
   logic [CW-1:0]   door_cnt_q, door_cnt_d;
   logic            served_q, served_d;
   logic            load_valid;

   assign load_valid = (ctrl_load == 4'h1) || (ctrl_load == 4'h2) ||
                       (ctrl_load == 4'h4) || (ctrl_load == 4'h8);

   always_comb begin
      state_d      = state_q;
      ctrl_seq_d   = ctrl_seq_q;
      floor_d      = floor_q;
      travel_cnt_d = travel_cnt_q;
      door_cnt_d   = door_cnt_q;
      served_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (load_valid) begin
               ctrl_seq_d   = ctrl_load;
               travel_cnt_d = '0;
               door_cnt_d   = '0;
               // One-hot codes order the same way as floor numbers
               if (ctrl_load > floor_q) begin
                  state_d = MOVE_UP;
               end else if (ctrl_load < floor_q) begin
                  state_d = MOVE_DOWN;
               end else begin
                  state_d = DOOR;
               end
            end
         end
         MOVE_UP: begin
            if (travel_cnt_q == TRAVEL_LAST) begin
               floor_d      = floor_q[3] ? floor_q : {floor_q[2:0], 1'b0};
               travel_cnt_d = '0;
               if (floor_d == ctrl_seq_q) begin
                  state_d    = DOOR;
                  door_cnt_d = '0;
               end
            end else begin
               travel_cnt_d = travel_cnt_q + 1'b1;
            end
         end
         MOVE_DOWN: begin
            if (travel_cnt_q == TRAVEL_LAST) begin
               floor_d      = floor_q[0] ? floor_q : {1'b0, floor_q[3:1]};
               travel_cnt_d = '0;
               if (floor_d == ctrl_seq_q) begin
                  state_d    = DOOR;
                  door_cnt_d = '0;
               end
            end else begin
               travel_cnt_d = travel_cnt_q + 1'b1;
            end
         end
         DOOR: begin
            if (door_cnt_q == DOOR_LAST) begin
               ctrl_seq_d = 4'h0;
               served_d   = 1'b1;
               door_cnt_d = '0;
               state_d    = IDLE;
            end else begin
               door_cnt_d = door_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         ctrl_seq_q   <= 4'h0;
         floor_q      <= 4'h1;
         travel_cnt_q <= '0;
         door_cnt_q   <= '0;
         served_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         ctrl_seq_q   <= ctrl_seq_d;
         floor_q      <= floor_d;
         travel_cnt_q <= travel_cnt_d;
         door_cnt_q   <= door_cnt_d;
         served_q     <= served_d;
      end
   end

   assign ctrl_seq   = ctrl_seq_q;
   assign floor      = floor_q;
   assign motor_up   = (state_q == MOVE_UP);
   assign motor_down = (state_q == MOVE_DOWN);
   assign door_open  = (state_q == DOOR);
   assign served     = served_q;

endmodule

// File: tb/tb_elevator_motion_controller.sv
// Bench for elevator_motion_controller with TRAVEL_TICKS=4, DOOR_TICKS=3.
// Each step queues the inputs for one edge and the outputs expected after it.
module tb_elevator_motion_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] ctrl_load = 4'h0;
   logic [3:0] ctrl_seq;
   logic [3:0] floor;
   logic       motor_up;
   logic       motor_down;
   logic       door_open;
   logic       served;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        rst;
      logic [3:0]  drv;
      logic [11:0] exp;
   } step_t;

   step_t sb[$];
   step_t st;
   logic [11:0] obs;

   elevator_motion_controller #(
      .TRAVEL_TICKS(4),
      .DOOR_TICKS  (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ctrl_load (ctrl_load),
      .ctrl_seq  (ctrl_seq),
      .floor     (floor),
      .motor_up  (motor_up),
      .motor_down(motor_down),
      .door_open (door_open),
      .served    (served)
   );

   always #5 clk = ~clk;

   assign obs = {ctrl_seq, floor, motor_up, motor_down, door_open, served};

   function automatic logic [11:0] ev(input logic [3:0] s, input logic [3:0] f,
                                      input logic mu, input logic md,
                                      input logic dr, input logic sv);
      return {s, f, mu, md, dr, sv};
   endfunction

   function automatic void push(input logic r, input logic [3:0] d,
                                input logic [11:0] e, input int n);
      step_t t;
      t.rst = r;
      t.drv = d;
      t.exp = e;
      for (int i = 0; i < n; i++) sb.push_back(t);
   endfunction

   task automatic test_reset();
      push(1'b1, 4'h0, ev(4'h0, 4'h1, 0, 0, 0, 0), 2);
      push(1'b0, 4'h0, ev(4'h0, 4'h1, 0, 0, 0, 0), 1);
      while (sb.size() > 0) begin
         st = sb.pop_front();
         rst = st.rst;
         ctrl_load = st.drv;
         @(negedge clk);
         vectors++;
         if (obs !== st.exp) begin
            miscompares++;
            $display("FAIL reset: got %h want %h at %0t", obs, st.exp, $time);
         end
      end
   endtask

   task automatic test_idle_ignore();
      push(1'b0, 4'h6, ev(4'h0, 4'h1, 0, 0, 0, 0), 2);
      push(1'b0, 4'h0, ev(4'h0, 4'h1, 0, 0, 0, 0), 1);
      push(1'b0, 4'hF, ev(4'h0, 4'h1, 0, 0, 0, 0), 1);
      push(1'b0, 4'h0, ev(4'h0, 4'h1, 0, 0, 0, 0), 1);
      while (sb.size() > 0) begin
         st = sb.pop_front();
         rst = st.rst;
         ctrl_load = st.drv;
         @(negedge clk);
         vectors++;
         if (obs !== st.exp) begin
            miscompares++;
            $display("FAIL idle_ignore: got %h want %h at %0t", obs, st.exp, $time);
         end
      end
   endtask

   task automatic test_same_floor();
      push(1'b0, 4'h1, ev(4'h1, 4'h1, 0, 0, 1, 0), 1);
      push(1'b0, 4'h0, ev(4'h1, 4'h1, 0, 0, 1, 0), 2);
      push(1'b0, 4'h0, ev(4'h0, 4'h1, 0, 0, 0, 1), 1);
      push(1'b0, 4'h0, ev(4'h0, 4'h1, 0, 0, 0, 0), 1);
      while (sb.size() > 0) begin
         st = sb.pop_front();
         rst = st.rst;
         ctrl_load = st.drv;
         @(negedge clk);
         vectors++;
         if (obs !== st.exp) begin
            miscompares++;
            $display("FAIL same_floor: got %h want %h at %0t", obs, st.exp, $time);
         end
      end
   endtask

   task automatic test_up_trip();
      push(1'b0, 4'h4, ev(4'h4, 4'h1, 1, 0, 0, 0), 1);
      push(1'b0, 4'h0, ev(4'h4, 4'h1, 1, 0, 0, 0), 3);
      push(1'b0, 4'h0, ev(4'h4, 4'h2, 1, 0, 0, 0), 4);
      push(1'b0, 4'h0, ev(4'h4, 4'h4, 0, 0, 1, 0), 3);
      push(1'b0, 4'h0, ev(4'h0, 4'h4, 0, 0, 0, 1), 1);
      push(1'b0, 4'h0, ev(4'h0, 4'h4, 0, 0, 0, 0), 1);
      while (sb.size() > 0) begin
         st = sb.pop_front();
         rst = st.rst;
         ctrl_load = st.drv;
         @(negedge clk);
         vectors++;
         if (obs !== st.exp) begin
            miscompares++;
            $display("FAIL up_trip: got %h want %h at %0t", obs, st.exp, $time);
         end
      end
   endtask

   task automatic test_ignore_in_trip();
      push(1'b1, 4'h0, ev(4'h0, 4'h1, 0, 0, 0, 0), 1);
      push(1'b0, 4'h4, ev(4'h4, 4'h1, 1, 0, 0, 0), 1);
      push(1'b0, 4'h8, ev(4'h4, 4'h1, 1, 0, 0, 0), 3);
      push(1'b0, 4'h8, ev(4'h4, 4'h2, 1, 0, 0, 0), 4);
      push(1'b0, 4'h8, ev(4'h4, 4'h4, 0, 0, 1, 0), 3);
      push(1'b0, 4'h0, ev(4'h0, 4'h4, 0, 0, 0, 1), 1);
      push(1'b0, 4'h0, ev(4'h0, 4'h4, 0, 0, 0, 0), 1);
      while (sb.size() > 0) begin
         st = sb.pop_front();
         rst = st.rst;
         ctrl_load = st.drv;
         @(negedge clk);
         vectors++;
         if (obs !== st.exp) begin
            miscompares++;
            $display("FAIL ignore_in_trip: got %h want %h at %0t", obs, st.exp, $time);
         end
      end
   endtask

   task automatic test_back_to_back();
      push(1'b0, 4'h8, ev(4'h8, 4'h4, 1, 0, 0, 0), 1);
      push(1'b0, 4'h0, ev(4'h8, 4'h4, 1, 0, 0, 0), 3);
      push(1'b0, 4'h0, ev(4'h8, 4'h8, 0, 0, 1, 0), 3);
      push(1'b0, 4'h0, ev(4'h0, 4'h8, 0, 0, 0, 1), 1);
      push(1'b0, 4'h0, ev(4'h0, 4'h8, 0, 0, 0, 0), 1);
      push(1'b0, 4'h1, ev(4'h1, 4'h8, 0, 1, 0, 0), 4);
      push(1'b0, 4'h1, ev(4'h1, 4'h4, 0, 1, 0, 0), 4);
      push(1'b0, 4'h1, ev(4'h1, 4'h2, 0, 1, 0, 0), 4);
      push(1'b0, 4'h1, ev(4'h1, 4'h1, 0, 0, 1, 0), 3);
      push(1'b0, 4'h1, ev(4'h0, 4'h1, 0, 0, 0, 1), 1);
      push(1'b0, 4'h1, ev(4'h1, 4'h1, 0, 0, 1, 0), 1);
      push(1'b0, 4'h0, ev(4'h1, 4'h1, 0, 0, 1, 0), 2);
      push(1'b0, 4'h0, ev(4'h0, 4'h1, 0, 0, 0, 1), 1);
      push(1'b0, 4'h0, ev(4'h0, 4'h1, 0, 0, 0, 0), 1);
      while (sb.size() > 0) begin
         st = sb.pop_front();
         rst = st.rst;
         ctrl_load = st.drv;
         @(negedge clk);
         vectors++;
         if (obs !== st.exp) begin
            miscompares++;
            $display("FAIL back_to_back: got %h want %h at %0t", obs, st.exp, $time);
         end
      end
   endtask

   task automatic test_reset_mid_travel();
      push(1'b0, 4'h4, ev(4'h4, 4'h1, 1, 0, 0, 0), 1);
      push(1'b0, 4'h0, ev(4'h4, 4'h1, 1, 0, 0, 0), 3);
      push(1'b0, 4'h0, ev(4'h4, 4'h2, 1, 0, 0, 0), 2);
      push(1'b1, 4'h0, ev(4'h0, 4'h1, 0, 0, 0, 0), 1);
      push(1'b0, 4'h0, ev(4'h0, 4'h1, 0, 0, 0, 0), 3);
      push(1'b0, 4'h8, ev(4'h8, 4'h1, 1, 0, 0, 0), 1);
      push(1'b1, 4'h0, ev(4'h0, 4'h1, 0, 0, 0, 0), 1);
      push(1'b0, 4'h0, ev(4'h0, 4'h1, 0, 0, 0, 0), 2);
      while (sb.size() > 0) begin
         st = sb.pop_front();
         rst = st.rst;
         ctrl_load = st.drv;
         @(negedge clk);
         vectors++;
         if (obs !== st.exp) begin
            miscompares++;
            $display("FAIL reset_mid_travel: got %h want %h at %0t", obs, st.exp, $time);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle_ignore();
      test_same_floor();
      test_up_trip();
      test_ignore_in_trip();
      test_back_to_back();
      test_reset_mid_travel();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/elevator_motion_controller.md
ELEVATOR_MOTION_CONTROLLER -- requirements
Module: elevator_motion_controller

Interface
REQ-001 Parameter TRAVEL_TICKS, default 100, clk cycles to move the car one floor.
REQ-002 Parameter DOOR_TICKS, default 200, clk cycles the door stays open on arrival.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ctrl_load  input  4  one-hot floor request from the input controller; bit0 = floor 1 ... bit3 = floor 4.
REQ-006 ctrl_seq  output  4  latched request in service, one-hot; 4'h0 = free to accept a new request.
REQ-007 floor  output  4  current car floor, one-hot.
REQ-008 motor_up  output  1  car driven upward.
REQ-009 motor_down  output  1  car driven downward.
REQ-010 door_open  output  1  door open.
REQ-011 served  output  1  one-cycle pulse when a request completes.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
REQ-013 Valid request: ctrl_load is exactly one of 4'h1, 4'h2, 4'h4, 4'h8; any other value, including 4'h0, SHALL be ignored.
REQ-014 In IDLE with a valid request, ctrl_seq SHALL load ctrl_load at that edge, and the state SHALL become MOVE_UP if target > floor, MOVE_DOWN if target < floor, DOOR if target == floor.
REQ-015 Outside IDLE, ctrl_load SHALL be ignored; ctrl_seq SHALL hold its value until the request completes.
REQ-016 motor_up SHALL be 1 only in MOVE_UP; motor_down only in MOVE_DOWN; door_open only in DOOR; all are decoded from the registered state, with no combinational path from ctrl_load.
REQ-017 The travel counter SHALL clear to 0 on entry to MOVE_UP or MOVE_DOWN, and otherwise increment each cycle in those states.
REQ-018 At the edge where the travel counter == TRAVEL_TICKS-1:
  - floor SHALL shift one position (left for up, right for down);
  - the counter SHALL clear;
  - if the new floor equals ctrl_seq, the state SHALL become DOOR at the same edge.
REQ-019 floor SHALL never leave the range 4'h1..4'h8; a shift beyond floor 4 or below floor 1 SHALL NOT occur, because the target is always a valid floor.
REQ-020 The door counter SHALL clear on entry to DOOR and increment each DOOR cycle; door_open SHALL last exactly DOOR_TICKS cycles.
REQ-021 At the edge where the door counter == DOOR_TICKS-1:
  - ctrl_seq SHALL become 4'h0;
  - served SHALL be 1 for the following cycle only;
  - the state SHALL become IDLE.
REQ-022 A valid request present on the first IDLE cycle after served SHALL be accepted at that edge (no dead cycle).
REQ-023 Counters SHALL be wide enough for TRAVEL_TICKS and DOOR_TICKS up to 2^24.
REQ-024 motor_up, motor_down and door_open SHALL never be 1 simultaneously (mutual exclusion by state).

Reset
REQ-025 While rst=1 at a posedge, the outputs SHALL take these values:
  - state = IDLE;
  - ctrl_seq = 4'h0;
  - floor = 4'h1;
  - motor_up = 0, motor_down = 0, door_open = 0, served = 0;
  - both counters = 0.
REQ-026 Reset SHALL take priority over all other events, including mid-travel and mid-door; the pending request SHALL be discarded.

Verification (TRAVEL_TICKS=4, DOOR_TICKS=3)
REQ-027 Reset: rst=1 for 2 cycles -> floor=4'h1, ctrl_seq=4'h0, all motor/door/served=0.
REQ-028 Up trip: from floor 1, ctrl_load=4'h4 for 1 cycle ->
  - ctrl_seq=4'h4 next cycle;
  - motor_up=1 for 8 cycles;
  - floor=4'h2 after 4 cycles, 4'h4 after 8;
  - door_open=1 for 3 cycles;
  - served pulse, then ctrl_seq=4'h0.
REQ-029 Same floor: at floor 1, ctrl_load=4'h1 -> no motor activity; door_open=1 for 3 cycles; served pulse.
REQ-030 Ignored inputs: ctrl_load=4'h6 in IDLE -> state unchanged. ctrl_load=4'h8 during an up trip to 4'h4 -> ctrl_seq stays 4'h4; car stops at floor 3.
REQ-031 Down trip and back-to-back: at floor 4, ctrl_load=4'h1 held through completion ->
  - motor_down=1 for 12 cycles;
  - floor=4'h1;
  - door, served;
  - next edge re-accepts 4'h1 and goes directly to DOOR.
REQ-032 Reset mid-travel: rst=1 during motor_up with floor=4'h2 -> next cycle floor=4'h1, ctrl_seq=4'h0, IDLE, motors 0.
